// File: rtl/signed_seq_divider.sv
// Iterative signed non-restoring radix-2 divider with valid/ready handshake.
// Optional `SEQ_DIV_ZERO_FASTPATH_EN skips the iterations for a zero divisor.
module signed_seq_divider #(
  parameter int p_width = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic signed [p_width-1:0] dividend_i,
  input  logic signed [p_width-1:0] divisor_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic signed [p_width-1:0] quotient_o,
  output logic signed [p_width-1:0] remainder_o,
  output logic                      div_zero_o,
  output logic                      valid_o,
  input  logic                      ready_i
);

  localparam int cnt_w = $clog2(p_width + 1);
  localparam logic [cnt_w-1:0] last_iter = cnt_w'(p_width - 1);

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t             state;
  logic [cnt_w-1:0]   count;
  logic [p_width+1:0] acc;
  logic [p_width-1:0] dq;
  logic [p_width:0]   dmag;
  logic [p_width-1:0] dividend_raw;
  logic               q_neg;
  logic               r_neg;
  logic               zero;

  logic [p_width-1:0] a_mag;
  logic [p_width:0]   b_mag;
  logic               b_zero;
  logic [p_width+1:0] dext;
  logic [p_width+1:0] shifted;
  logic [p_width+1:0] acc_next;
  logic [p_width-1:0] dq_next;
  logic [p_width-1:0] rem_mag;

  // The partial remainder is p_width+2 bits signed: it stays within +-2*|divisor|.
  always_comb begin
    a_mag    = dividend_i[p_width-1] ? -dividend_i : dividend_i;
    b_mag    = {1'b0, (divisor_i[p_width-1] ? -divisor_i : divisor_i)};
    b_zero   = (divisor_i == '0);
    dext     = {1'b0, dmag};
    shifted  = {acc[p_width:0], dq[p_width-1]};
    acc_next = acc[p_width+1] ? (shifted + dext) : (shifted - dext);
    dq_next  = {dq[p_width-2:0], ~acc_next[p_width+1]};
    rem_mag  = acc[p_width-1:0] + (acc[p_width+1] ? dmag[p_width-1:0] : '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      count        <= '0;
      acc          <= '0;
      dq           <= '0;
      dmag         <= '0;
      dividend_raw <= '0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      zero         <= 1'b0;
      ready_o      <= 1'b1;
      valid_o      <= 1'b0;
      quotient_o   <= '0;
      remainder_o  <= '0;
      div_zero_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i && ready_o) begin
            acc          <= '0;
            count        <= '0;
            dq           <= a_mag;
            dmag         <= b_mag;
            dividend_raw <= dividend_i;
            q_neg        <= dividend_i[p_width-1] ^ divisor_i[p_width-1];
            r_neg        <= dividend_i[p_width-1];
            zero         <= b_zero;
            ready_o      <= 1'b0;
`ifdef SEQ_DIV_ZERO_FASTPATH_EN
            state        <= b_zero ? FIX : BUSY;
`else
            state        <= BUSY;
`endif
          end
        end
        BUSY: begin
          acc   <= acc_next;
          dq    <= dq_next;
          count <= count + 1'b1;
          if (count == last_iter) state <= FIX;
        end
        FIX: begin
          // Magnitude quotient bits are final; only the remainder needs the restore step.
          if (zero) begin
            quotient_o  <= '1;
            remainder_o <= dividend_raw;
          end else begin
            quotient_o  <= q_neg ? -dq : dq;
            remainder_o <= r_neg ? -rem_mag : rem_mag;
          end
          div_zero_o <= zero;
          valid_o    <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
